// File: rtl/vproc_bf16_unpack.sv
// -----------------------------------------------------------------------------
// vproc_bf16_unpack
//   Operand-unpack stage in front of the BF16 vector unit. Each BF16_OP_W-bit
//   operand word is split into N = BF16_OP_W/16 BF16 elements. Every element is
//   decoded into sign / effective exponent / mantissa (hidden bit explicit) and
//   a one-hot class, then held in a 2-entry skid buffer. ctrl and mask travel
//   with the word unchanged.
//
//   Unpacked element layout (23 bits):
//     [22]    sign
//     [21:14] effective exponent
//     [13:6]  mantissa {hidden, frac[6:0]}
//     [5:0]   class one-hot {snan, qnan, inf, sub, zero, norm}
//
// Ports
//   clk_i             clock
//   async_rst_ni      asynchronous active-low reset
//   pipe_in_valid_i   input word valid
//   pipe_in_ready_o   stage can accept (registered)
//   pipe_in_ctrl_i    control, carried through
//   pipe_in_op1_i     packed BF16 operand 1
//   pipe_in_op2_i     packed BF16 operand 2
//   pipe_in_mask_i    byte mask
//   pipe_out_valid_o  unpacked word valid
//   pipe_out_ready_i  downstream accepts
//   pipe_out_ctrl_o   control, registered copy
//   pipe_out_op1_o    unpacked operand 1, element i at [23i+:23]
//   pipe_out_op2_o    unpacked operand 2, same layout
//   pipe_out_mask_o   byte mask, registered copy
// -----------------------------------------------------------------------------
module vproc_bf16_unpack #(
  parameter int unsigned BF16_OP_W      = 64,
  parameter type         CTRL_T         = logic,
  parameter logic        FLUSH_SUBNORM  = 1'b0,
  parameter logic        DONT_CARE_ZERO = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     async_rst_ni,
  input  logic                     pipe_in_valid_i,
  output logic                     pipe_in_ready_o,
  input  CTRL_T                    pipe_in_ctrl_i,
  input  logic [BF16_OP_W-1:0]     pipe_in_op1_i,
  input  logic [BF16_OP_W-1:0]     pipe_in_op2_i,
  input  logic [BF16_OP_W/8-1:0]   pipe_in_mask_i,
  output logic                     pipe_out_valid_o,
  input  logic                     pipe_out_ready_i,
  output CTRL_T                    pipe_out_ctrl_o,
  output logic [23*(BF16_OP_W/16)-1:0] pipe_out_op1_o,
  output logic [23*(BF16_OP_W/16)-1:0] pipe_out_op2_o,
  output logic [BF16_OP_W/8-1:0]   pipe_out_mask_o
);

  localparam int N      = int'(BF16_OP_W / 16);
  localparam int OUT_W  = 23 * N;
  localparam int MASK_W = int'(BF16_OP_W / 8);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Decode one raw BF16 element into the 23-bit unpacked form.
  function automatic logic [22:0] decode_elem(input logic [15:0] e);
    logic       s;
    logic [7:0] ex;
    logic [6:0] fr;
    logic [22:0] res;
    s  = e[15];
    ex = e[14:7];
    fr = e[6:0];
    if (ex == 8'h00) begin
      if (fr == 7'h00) begin
        res = {s, 8'h00, 8'h00, 6'b000010};
      end else if (FLUSH_SUBNORM) begin
        res = {s, 8'h00, 8'h00, 6'b000010};
      end else begin
        // Subnormals use effective exponent 1 with the hidden bit cleared.
        res = {s, 8'h01, {1'b0, fr}, 6'b000100};
      end
    end else if (ex == 8'hFF) begin
      if (fr == 7'h00) begin
        res = {s, 8'hFF, 8'h80, 6'b001000};
      end else if (fr[6]) begin
        res = {s, 8'hFF, {1'b1, fr}, 6'b010000};
      end else begin
        res = {s, 8'hFF, {1'b1, fr}, 6'b100000};
      end
    end else begin
      res = {s, ex, {1'b1, fr}, 6'b000001};
    end
    return res;
  endfunction

  state_e              state_r;
  logic                in_ready_r;
  logic                out_valid_r;

  CTRL_T               main_ctrl_r;
  logic [OUT_W-1:0]    main_op1_r;
  logic [OUT_W-1:0]    main_op2_r;
  logic [MASK_W-1:0]   main_mask_r;

  CTRL_T               skid_ctrl_r;
  logic [OUT_W-1:0]    skid_op1_r;
  logic [OUT_W-1:0]    skid_op2_r;
  logic [MASK_W-1:0]   skid_mask_r;

  logic [OUT_W-1:0]    dec_op1_s;
  logic [OUT_W-1:0]    dec_op2_s;
  logic                in_fire_s;
  logic                out_fire_s;

  assign in_fire_s  = pipe_in_valid_i & in_ready_r;
  assign out_fire_s = out_valid_r & pipe_out_ready_i;

  // Element-wise decode of both incoming operands (mask does not gate decode).
  always_comb begin
    dec_op1_s = '0;
    dec_op2_s = '0;
    for (int i = 0; i < N; i++) begin
      dec_op1_s[23*i +: 23] = decode_elem(pipe_in_op1_i[16*i +: 16]);
      dec_op2_s[23*i +: 23] = decode_elem(pipe_in_op2_i[16*i +: 16]);
    end
  end

  // Skid-buffer controller with registered handshake flags and payload.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      main_ctrl_r <= '0;
      main_op1_r  <= '0;
      main_op2_r  <= '0;
      main_mask_r <= '0;
      skid_ctrl_r <= '0;
      skid_op1_r  <= '0;
      skid_op2_r  <= '0;
      skid_mask_r <= '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          // Skid never holds data here; clear it when requested.
          if (DONT_CARE_ZERO) begin
            skid_ctrl_r <= '0;
            skid_op1_r  <= '0;
            skid_op2_r  <= '0;
            skid_mask_r <= '0;
          end
          if (in_fire_s) begin
            main_ctrl_r <= pipe_in_ctrl_i;
            main_op1_r  <= dec_op1_s;
            main_op2_r  <= dec_op2_s;
            main_mask_r <= pipe_in_mask_i;
            state_r     <= ST_ONE;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
          end else if (DONT_CARE_ZERO) begin
            main_ctrl_r <= '0;
            main_op1_r  <= '0;
            main_op2_r  <= '0;
            main_mask_r <= '0;
          end
        end
        ST_ONE: begin
          if (DONT_CARE_ZERO) begin
            skid_ctrl_r <= '0;
            skid_op1_r  <= '0;
            skid_op2_r  <= '0;
            skid_mask_r <= '0;
          end
          if (in_fire_s && out_fire_s) begin
            // Pass-through: new word replaces the one leaving.
            main_ctrl_r <= pipe_in_ctrl_i;
            main_op1_r  <= dec_op1_s;
            main_op2_r  <= dec_op2_s;
            main_mask_r <= pipe_in_mask_i;
          end else if (in_fire_s) begin
            // Downstream stalled: park the new word in the skid entry.
            skid_ctrl_r <= pipe_in_ctrl_i;
            skid_op1_r  <= dec_op1_s;
            skid_op2_r  <= dec_op2_s;
            skid_mask_r <= pipe_in_mask_i;
            state_r     <= ST_FULL;
            in_ready_r  <= 1'b0;
          end else if (out_fire_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            if (DONT_CARE_ZERO) begin
              main_ctrl_r <= '0;
              main_op1_r  <= '0;
              main_op2_r  <= '0;
              main_mask_r <= '0;
            end
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            main_ctrl_r <= skid_ctrl_r;
            main_op1_r  <= skid_op1_r;
            main_op2_r  <= skid_op2_r;
            main_mask_r <= skid_mask_r;
            state_r     <= ST_ONE;
            in_ready_r  <= 1'b1;
            if (DONT_CARE_ZERO) begin
              skid_ctrl_r <= '0;
              skid_op1_r  <= '0;
              skid_op2_r  <= '0;
              skid_mask_r <= '0;
            end
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign pipe_in_ready_o  = in_ready_r;
  assign pipe_out_valid_o = out_valid_r;
  assign pipe_out_ctrl_o  = main_ctrl_r;
  assign pipe_out_op1_o   = main_op1_r;
  assign pipe_out_op2_o   = main_op2_r;
  assign pipe_out_mask_o  = main_mask_r;

endmodule
